// File: rtl/spi_reg_host_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_host_pkg
// Description : Shared types, frame layout and helpers for the SPI register host.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_reg_host_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETUP    = 3'd1,
    HDR      = 3'd2,
    WAIT_RDY = 3'd3,
    DATA     = 3'd4,
    HOLD     = 3'd5,
    GAP      = 3'd6
  } state_e;

  localparam int HDR_BITS      = 16;
  localparam int DATA_BITS     = 32;
  localparam int FRAME_BITS    = HDR_BITS + DATA_BITS;
  localparam int BIT_CNT_W     = 6;
  localparam int ADDR_W        = 6;
  localparam int HDR_RW_POS    = 15;
  localparam int HDR_WIDTH_LSB = 13;

  localparam logic [1:0] WIDTH_8    = 2'b00;
  localparam logic [1:0] WIDTH_16   = 2'b01;
  localparam logic [1:0] WIDTH_32   = 2'b10;
  localparam logic [1:0] WIDTH_RSVD = 2'b11;

  function automatic logic [1:0] norm_width(input logic [1:0] w);
    logic [1:0] r;
    r = (w == WIDTH_RSVD) ? WIDTH_32 : w;
    return r;
  endfunction

  function automatic logic [HDR_BITS-1:0] build_header(
    input logic              rw,
    input logic [1:0]        w,
    input logic [ADDR_W-1:0] a
  );
    logic [HDR_BITS-1:0] h;
    h                       = '0;
    h[HDR_RW_POS]           = rw;
    h[HDR_WIDTH_LSB +: 2]   = w;
    h[ADDR_W-1:0]           = a;
    return h;
  endfunction

  function automatic logic [DATA_BITS-1:0] mask_rdata(
    input logic [1:0]           w,
    input logic [DATA_BITS-1:0] d
  );
    logic [DATA_BITS-1:0] r;
    case (w)
      WIDTH_8:  r = {24'h0, d[7:0]};
      WIDTH_16: r = {16'h0, d[15:0]};
      default:  r = d;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_reg_host_shift.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_host_shift
// Description : 48-bit frame shifter with SCLK half-period and bit counters.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_host_shift
  import spi_reg_host_pkg::*;
#(
  parameter int HALF_PERIOD = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_load,
  input  logic [FRAME_BITS-1:0] i_load_data,
  input  logic                  i_run,
  input  logic                  i_sin,
  output logic                  o_sclk,
  output logic                  o_mosi,
  output logic                  o_bit_done,
  output logic [BIT_CNT_W-1:0]  o_bit_cnt,
  output logic [DATA_BITS-1:0]  o_data
);

  localparam int HC_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam logic [HC_W-1:0] c_hc_last = HC_W'(HALF_PERIOD - 1);

  logic [FRAME_BITS-1:0] r_sr;
  logic [HC_W-1:0]       r_hcnt;
  logic                  r_high;
  logic [BIT_CNT_W-1:0]  r_bcnt;
  logic                  w_half_end;

  assign w_half_end = i_run && (r_hcnt == c_hc_last);
  // A bit cell ends on the last cycle of its high phase; that is also the MISO sample point.
  assign o_bit_done = w_half_end && r_high;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr   <= '0;
      r_hcnt <= '0;
      r_high <= 1'b0;
      r_bcnt <= '0;
    end else if (i_load) begin
      r_sr   <= i_load_data;
      r_hcnt <= '0;
      r_high <= 1'b0;
      r_bcnt <= '0;
    end else if (i_run) begin
      if (w_half_end) begin
        r_hcnt <= '0;
        r_high <= ~r_high;
        if (r_high) begin
          r_sr   <= {r_sr[FRAME_BITS-2:0], i_sin};
          r_bcnt <= r_bcnt + 1'b1;
        end
      end else begin
        r_hcnt <= r_hcnt + 1'b1;
      end
    end
  end

  assign o_sclk    = r_high;
  assign o_mosi    = r_sr[FRAME_BITS-1];
  assign o_bit_cnt = r_bcnt;
  assign o_data    = r_sr[DATA_BITS-1:0];

endmodule
`default_nettype wire

// File: rtl/sync_ff.sv
`default_nettype none
// ============================================================================
// Module      : sync_ff
// Description : Multi-stage flip-flop synchronizer for asynchronous inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_ff #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_stage [STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) r_stage[i] <= '0;
    end else begin
      r_stage[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_q = r_stage[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/spi_reg_host.sv
`default_nettype none
// ============================================================================
// Module      : spi_reg_host
// Description : SPI master issuing single register read/write transactions.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_reg_host
  import spi_reg_host_pkg::*;
#(
  parameter int HALF_PERIOD   = 8,
  parameter int READY_TIMEOUT = 1023
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_width,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_BITS-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [DATA_BITS-1:0] rsp_rdata,
  output logic                 rsp_error,
  output logic                 spi_cs_n,
  output logic                 spi_clk,
  output logic                 spi_mosi,
  input  logic                 spi_miso,
  input  logic                 data_ready_in
);

  localparam int CNT_MAX = (READY_TIMEOUT > 2*HALF_PERIOD) ? READY_TIMEOUT : 2*HALF_PERIOD;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0]     c_h_last     = CNT_W'(HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0]     c_gap_last   = CNT_W'(2*HALF_PERIOD - 1);
  localparam logic [CNT_W-1:0]     c_to_last    = CNT_W'(READY_TIMEOUT - 1);
  localparam logic [BIT_CNT_W-1:0] c_hdr_last   = BIT_CNT_W'(HDR_BITS - 1);
  localparam logic [BIT_CNT_W-1:0] c_frame_last = BIT_CNT_W'(FRAME_BITS - 1);

  state_e                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_write;
  logic [1:0]            r_width;
  logic                  r_rdy_flag;
  logic                  r_err;
  logic                  r_cs_n;
  logic                  r_req_ready;
  logic                  r_rsp_valid;
  logic [DATA_BITS-1:0]  r_rsp_rdata;
  logic                  r_rsp_error;

  logic [1:0]            w_sync_out;
  logic                  w_miso_s;
  logic                  w_rdy_s;
  logic                  w_accept;
  logic [FRAME_BITS-1:0] w_load_data;
  logic                  w_run;
  logic                  w_sin;
  logic                  w_bit_done;
  logic [BIT_CNT_W-1:0]  w_bit_cnt;
  logic [DATA_BITS-1:0]  w_shift_data;
  logic                  w_rdy_window;

  sync_ff #(
    .STAGES (2),
    .WIDTH  (2)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d ({data_ready_in, spi_miso}),
    .o_q (w_sync_out)
  );

  assign w_miso_s = w_sync_out[0];
  assign w_rdy_s  = w_sync_out[1];

  assign w_accept    = req_valid && r_req_ready;
  assign w_load_data = {build_header(req_write, norm_width(req_width), req_addr),
                        req_write ? req_wdata : {DATA_BITS{1'b0}}};
  assign w_run       = (r_state == HDR) || (r_state == DATA);
  // Only data-phase MISO enters the shifter, so MOSI returns to 0 once the frame drains.
  assign w_sin       = (r_state == DATA) && w_miso_s;
  assign w_rdy_window = ((r_state == HDR) && (w_bit_cnt == c_hdr_last)) || (r_state == WAIT_RDY);

  spi_reg_host_shift #(
    .HALF_PERIOD (HALF_PERIOD)
  ) u_shift (
    .clk         (clk),
    .rst         (rst),
    .i_load      (w_accept),
    .i_load_data (w_load_data),
    .i_run       (w_run),
    .i_sin       (w_sin),
    .o_sclk      (spi_clk),
    .o_mosi      (spi_mosi),
    .o_bit_done  (w_bit_done),
    .o_bit_cnt   (w_bit_cnt),
    .o_data      (w_shift_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_width     <= WIDTH_8;
      r_rdy_flag  <= 1'b0;
      r_err       <= 1'b0;
      r_cs_n      <= 1'b1;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_error <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (!r_write && w_rdy_window && w_rdy_s) r_rdy_flag <= 1'b1;

      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state     <= SETUP;
            r_cnt       <= '0;
            r_write     <= req_write;
            r_width     <= norm_width(req_width);
            r_rdy_flag  <= 1'b0;
            r_err       <= 1'b0;
            r_cs_n      <= 1'b0;
            r_req_ready <= 1'b0;
          end
        end
        SETUP: begin
          if (r_cnt == c_h_last) begin
            r_state <= HDR;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        HDR: begin
          if (w_bit_done && (w_bit_cnt == c_hdr_last)) begin
            r_state <= r_write ? DATA : WAIT_RDY;
            r_cnt   <= '0;
          end
        end
        WAIT_RDY: begin
          if (r_rdy_flag) begin
            r_state <= DATA;
          end else if (r_cnt == c_to_last) begin
            r_state <= HOLD;
            r_err   <= 1'b1;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DATA: begin
          if (w_bit_done && (w_bit_cnt == c_frame_last)) begin
            r_state <= HOLD;
            r_cnt   <= '0;
          end
        end
        HOLD: begin
          if (r_cnt == c_h_last) begin
            r_state     <= GAP;
            r_cnt       <= '0;
            r_cs_n      <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_rsp_error <= r_err;
            r_rsp_rdata <= (r_err || r_write) ? {DATA_BITS{1'b0}}
                                              : mask_rdata(r_width, w_shift_data);
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        GAP: begin
          if (r_cnt == c_gap_last) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_req_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_error = r_rsp_error;
  assign spi_cs_n  = r_cs_n;

endmodule
`default_nettype wire

// File: tb/tb_spi_reg_host.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_reg_host
// Description : Directed self-checking bench for spi_reg_host with a harness model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_reg_host;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [1:0]  req_width = 2'b00;
  logic [5:0]  req_addr = 6'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_error;
  logic        spi_cs_n;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_miso = 1'b0;
  logic        data_ready_in = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  spi_reg_host dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_write     (req_write),
    .req_width     (req_width),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_rdata     (rsp_rdata),
    .rsp_error     (rsp_error),
    .spi_cs_n      (spi_cs_n),
    .spi_clk       (spi_clk),
    .spi_mosi      (spi_mosi),
    .spi_miso      (spi_miso),
    .data_ready_in (data_ready_in)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Harness target model: captures MOSI on SCLK rise, drives MISO on SCLK fall.
  logic [31:0] mem [64];
  logic [47:0] t_shift = '0;
  logic [15:0] t_hdr = '0;
  logic [31:0] t_rd = '0;
  int          t_bits = 0;
  int          rdy_mode = 1;  // 0: ready 40 cycles after header, 1: never, 2: pulse in last header bit
  int          cs_rises = 0;

  always @(posedge spi_clk or negedge spi_cs_n) begin
    if (!spi_clk) begin
      t_bits  = 0;
      t_shift = '0;
    end else if (!spi_cs_n) begin
      t_shift = {t_shift[46:0], spi_mosi};
      t_bits++;
      if (t_bits == 16) begin
        t_hdr = t_shift[15:0];
        t_rd  = mem[t_shift[5:0]];
      end
      if (t_bits == 48 && t_hdr[15]) mem[t_hdr[5:0]] = t_shift[31:0];
    end
  end

  always @(negedge spi_clk or posedge spi_cs_n) begin
    if (spi_cs_n) begin
      data_ready_in = 1'b0;
      spi_miso      = 1'b0;
    end else begin
      if (t_bits >= 16 && t_bits < 48 && !t_hdr[15]) spi_miso = t_rd[47 - t_bits];
      if (t_bits == 16 && !t_hdr[15] && rdy_mode == 0) begin
        repeat (40) @(posedge clk);
        #1 data_ready_in = 1'b1;
      end
      if (t_bits == 15 && rdy_mode == 2) begin
        repeat (2) @(posedge clk);
        #1 data_ready_in = 1'b1;
        @(posedge clk);
        #1 data_ready_in = 1'b0;
      end
    end
  end

  always @(posedge spi_cs_n) cs_rises++;

  int          t_acc;
  int          rsp_cyc;
  logic [31:0] got_rdata;
  logic        got_err;

  task automatic start_req(input logic w, input logic [1:0] wd, input logic [5:0] a,
                           input logic [31:0] d);
    int n = 0;
    while (!req_ready && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_wait got %b exp 1", req_ready);
    end
    req_write = w; req_width = wd; req_addr = a; req_wdata = d;
    req_valid = 1'b1;
    t_acc = cyc;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int budget);
    int n = 0;
    while (!rsp_valid && n < budget) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL rsp_timeout got %b exp 1 after %0d cycles", rsp_valid, n);
    end
    rsp_cyc   = cyc;
    got_rdata = rsp_rdata;
    got_err   = rsp_error;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_error, spi_cs_n, spi_clk, spi_mosi} !== 6'b100100) begin
      errors++;
      $display("FAIL reset_ctrl got %b exp 100100",
               {req_ready, rsp_valid, rsp_error, spi_cs_n, spi_clk, spi_mosi});
    end
    checks++;
    if (rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata got %h exp 00000000", rsp_rdata);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_write();
    int n = 0;
    rdy_mode = 1;
    start_req(1'b1, 2'b10, 6'h05, 32'hDEADBEEF);
    checks++;
    if ({spi_cs_n, spi_mosi} !== 2'b01) begin
      errors++;
      $display("FAIL wr_setup cs/mosi got %b exp 01", {spi_cs_n, spi_mosi});
    end
    while (!spi_clk && n < 100) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (cyc - t_acc !== 17) begin
      errors++;
      $display("FAIL wr_first_sclk got %0d exp 17", cyc - t_acc);
    end
    wait_rsp(1000);
    checks++;
    if (rsp_cyc - t_acc !== 785) begin
      errors++;
      $display("FAIL wr_rsp_cycle got %0d exp 785", rsp_cyc - t_acc);
    end
    checks++;
    if ({got_err, got_rdata} !== 33'h0) begin
      errors++;
      $display("FAIL wr_rsp err/rdata got %b/%h exp 0/00000000", got_err, got_rdata);
    end
    checks++;
    if (spi_cs_n !== 1'b1) begin
      errors++;
      $display("FAIL wr_cs_at_rsp got %b exp 1", spi_cs_n);
    end
    checks++;
    if (t_hdr !== 16'hC005) begin
      errors++;
      $display("FAIL wr_header got %h exp c005", t_hdr);
    end
    checks++;
    if (mem[5] !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_reg05 got %h exp deadbeef", mem[5]);
    end
    @(posedge clk); #1;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr_rsp_pulse got %b exp 0", rsp_valid);
    end
    n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (cyc - t_acc !== 801) begin
      errors++;
      $display("FAIL wr_ready_cycle got %0d exp 801", cyc - t_acc);
    end
  endtask

  task automatic test_timeout();
    rdy_mode = 1;
    start_req(1'b0, 2'b10, 6'h05, 32'h0);
    wait_rsp(3000);
    checks++;
    if (got_err !== 1'b1 || got_rdata !== 32'h0) begin
      errors++;
      $display("FAIL to_rsp err/rdata got %b/%h exp 1/00000000", got_err, got_rdata);
    end
    checks++;
    if (rsp_cyc - t_acc !== 1296) begin
      errors++;
      $display("FAIL to_rsp_cycle got %0d exp 1296", rsp_cyc - t_acc);
    end
    checks++;
    if (t_bits !== 16) begin
      errors++;
      $display("FAIL to_sclk_edges got %0d exp 16", t_bits);
    end
  endtask

  task automatic test_read_delay();
    int cs0;
    rdy_mode = 0;
    cs0 = cs_rises;
    start_req(1'b0, 2'b00, 6'h05, 32'hFFFFFFFF);
    wait_rsp(2000);
    checks++;
    if (got_rdata !== 32'h000000EF || got_err !== 1'b0) begin
      errors++;
      $display("FAIL rd8_rsp rdata/err got %h/%b exp 000000ef/0", got_rdata, got_err);
    end
    checks++;
    if (rsp_cyc - t_acc !== 829) begin
      errors++;
      $display("FAIL rd8_rsp_cycle got %0d exp 829", rsp_cyc - t_acc);
    end
    checks++;
    if (cs_rises - cs0 !== 1) begin
      errors++;
      $display("FAIL rd8_cs_rises got %0d exp 1", cs_rises - cs0);
    end
    checks++;
    if (t_hdr !== 16'h0005 || t_shift[31:0] !== 32'h0) begin
      errors++;
      $display("FAIL rd8_mosi hdr/data got %h/%h exp 0005/00000000", t_hdr, t_shift[31:0]);
    end
  endtask

  task automatic test_ready_pulse();
    rdy_mode = 2;
    start_req(1'b0, 2'b01, 6'h05, 32'h0);
    wait_rsp(2000);
    checks++;
    if (got_rdata !== 32'h0000BEEF || got_err !== 1'b0) begin
      errors++;
      $display("FAIL pulse_rsp rdata/err got %h/%b exp 0000beef/0", got_rdata, got_err);
    end
    checks++;
    if (rsp_cyc - t_acc !== 786) begin
      errors++;
      $display("FAIL pulse_rsp_cycle got %0d exp 786", rsp_cyc - t_acc);
    end
  endtask

  task automatic test_rst_mid_data();
    int seen = 0;
    rdy_mode = 1;
    start_req(1'b1, 2'b10, 6'h11, 32'h0F0F0F0F);
    repeat (399) @(posedge clk);
    #1;
    checks++;
    if (spi_cs_n !== 1'b0) begin
      errors++;
      $display("FAIL rst_pre_cs got %b exp 0", spi_cs_n);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({spi_cs_n, spi_clk, spi_mosi, req_ready, rsp_valid, rsp_error} !== 6'b100100) begin
      errors++;
      $display("FAIL rst_outputs got %b exp 100100",
               {spi_cs_n, spi_clk, spi_mosi, req_ready, rsp_valid, rsp_error});
    end
    checks++;
    if (rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_rdata got %h exp 00000000", rsp_rdata);
    end
    rst = 1'b0;
    for (int i = 0; i < 900; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL rst_no_rsp got %0d exp 0", seen);
    end
  endtask

  task automatic test_back_to_back();
    int n = 0;
    int t1;
    int rise1;
    int acc2;
    rdy_mode = 1;
    req_write = 1'b1; req_width = 2'b01; req_addr = 6'h07; req_wdata = 32'hCAFEF00D;
    req_valid = 1'b1;
    t1 = cyc;
    @(posedge clk); #1;
    req_width = 2'b11; req_addr = 6'h0A; req_wdata = 32'h12345678;
    while (spi_cs_n == 1'b0 && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    rise1 = cyc;
    n = 0;
    while (spi_cs_n == 1'b1 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    acc2 = cyc - 1;
    req_valid = 1'b0;
    checks++;
    if (rise1 - t1 !== 785) begin
      errors++;
      $display("FAIL b2b_first_rise got %0d exp 785", rise1 - t1);
    end
    checks++;
    if (acc2 - rise1 !== 16) begin
      errors++;
      $display("FAIL b2b_gap got %0d exp 16", acc2 - rise1);
    end
    wait_rsp(1000);
    checks++;
    if (t_hdr !== 16'hC00A) begin
      errors++;
      $display("FAIL b2b_header got %h exp c00a", t_hdr);
    end
    checks++;
    if (mem[7] !== 32'hCAFEF00D || mem[10] !== 32'h12345678) begin
      errors++;
      $display("FAIL b2b_regs got %h/%h exp cafef00d/12345678", mem[7], mem[10]);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write();
    test_timeout();
    test_read_delay();
    test_ready_pulse();
    test_rst_mid_data();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
